mem_stage_sram_ctrl: RTL and testbench
======================================

Name: mem_stage_sram_ctrl

Overview:
Controller for the MEM-stage data memory, sharing one external 16-bit asynchronous SRAM with the pipeline's 32-bit load/store path. It takes the registered EXE-stage outputs (read enable, write enable, ALU result as address, Rm value as store data) and sequences two half-word SRAM accesses per request. It drops ready for the whole access; the pipeline uses ~ready as its global Freeze, so the EXE/MEM registers hold the request stable.

Parameters:
BASE_ADDR, 1024, byte address mapped to SRAM word 0.
WAIT_CYCLES, 2, cycles per half-word SRAM access (legal range 1..15).
SRAM_AW, 18, SRAM half-word address width.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous reset, active-low.
wr_en  in  1  store request (MEM_W_EN).
rd_en  in  1  load request (MEM_R_EN).
address  in  32  byte address (ALU result).
write_data  in  32  store data (Rm value).
read_data  out  32  load data, valid in DONE and held until the next load completes.
ready  out  1  0 = pipeline must freeze.
sram_addr  out  SRAM_AW  half-word address.
sram_dq_out  out  16  write data to SRAM.
sram_dq_oe  out  1  1 = controller drives the data bus.
sram_dq_in  in  16  read data from SRAM.
sram_we_n  out  1  SRAM write strobe, active-low.

Behaviour:
- States: IDLE, ACC_LO, ACC_HI, DONE. Wait counter is 4 bits.
- Reset (rst=0, async): state=IDLE, counter=0, read_data=0, sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
- Address mapping: word = (address - BASE_ADDR) >> 2, truncated to SRAM_AW-1 bits. sram_addr = {word, half}, where half=0 in ACC_LO and 1 in ACC_HI. No range check.
- Operation is latched in IDLE: op_write = wr_en, op_read = rd_en & ~wr_en. Write wins when both are asserted.
- IDLE: ready = ~(wr_en | rd_en), combinational, so a request freezes the pipeline in the same cycle. On a request, go to ACC_LO with counter=0.
- ACC_LO / ACC_HI:
  - Each state is held for exactly WAIT_CYCLES cycles; the counter increments each cycle and clears on state exit. ready=0.
  - Write: sram_dq_oe=1. sram_dq_out = write_data[15:0] in ACC_LO, write_data[31:16] in ACC_HI. sram_we_n=0 for the whole state except its final cycle (always 0 when WAIT_CYCLES=1).
  - Read: sram_dq_oe=0, sram_we_n=1. sram_dq_in is sampled on the final cycle of ACC_LO into read_data[15:0], and on the final cycle of ACC_HI into read_data[31:16].
- DONE: ready=1 for exactly one cycle, sram_we_n=1, sram_dq_oe=0. Then go to IDLE unconditionally. The pipeline advances on this edge, so inputs seen in the next IDLE cycle are a new request; the held request is never restarted.
- Latency per request: ready low for 1+2*WAIT_CYCLES cycles, then one DONE cycle (default: 5 low, 1 high).
- Back-to-back requests: IDLE lasts one cycle, with ready low immediately.
- Requests with neither enable: ready stays 1 and all SRAM outputs stay idle.
- Reset mid-access: abort to IDLE, deassert the write strobe; a partial SRAM write is acceptable.

Optional Feature:
SRAM_STALL_CNT_EN.
- Defined: extra output stall_cycles[31:0]. It counts every cycle with ready=0, wraps at 2^32 and resets to 0.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Package mem_sram_pkg holds:
  - the state enum (IDLE, ACC_LO, ACC_HI, DONE);
  - SRAM data width 16;
  - default BASE_ADDR;
  - default WAIT_CYCLES.
- One sub-module, sram_wait_counter. It is a parameterised up-counter with clr/en and a terminal-count flag (count == WAIT_CYCLES-1), used for both access states.

Test Plan:
1. Reset: assert rst=0 mid-simulation -> read_data=0, sram_we_n=1, sram_dq_oe=0; with no request, ready=1.
2. Store: wr_en=1, address=1032, write_data=0x1234ABCD, default params ->
   - sram_addr=4, dq_out=0xABCD for 2 cycles, then sram_addr=5, dq_out=0x1234 for 2 cycles;
   - we_n low in the first cycle of each pair;
   - ready=0 for 5 cycles, then 1 for one cycle.
3. Load: SRAM model preloaded from test 2, rd_en=1, address=1032 -> read_data=0x1234ABCD in the DONE cycle and held afterwards.
4. Both enables: rd_en=1, wr_en=1 -> write sequence occurs, read_data unchanged.
5. Reset during ACC_HI of a store -> IDLE on reset, sram_we_n=1 immediately. A following load of a different address completes normally.
6. WAIT_CYCLES=1 with back-to-back load then store -> ready pattern 0,0,0,1,0,0,0,1. With SRAM_STALL_CNT_EN defined, stall_cycles=6 afterwards.

Source files
------------

// File: rtl/mem_stage_sram_ctrl_pkg.sv
// mem_sram_pkg: shared state type and defaults for the MEM-stage SRAM controller
package mem_sram_pkg;
    typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI, DONE} state_t;
    localparam int SRAM_DW = 16;
    localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;
    localparam int DEF_WAIT_CYCLES = 2;
endpackage

// File: rtl/mem_stage_sram_ctrl_wait_counter.sv
// sram_wait_counter: per-state wait counter flagging the last cycle of a half-word access
module sram_wait_counter
    import mem_sram_pkg::*;
#(
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] count,
    output logic [3:0] count_next,
    output logic       tc
);
    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    always_comb count_next = clr ? 4'd0 : en ? count + 4'd1 : count;
    assign tc = count == LAST;

    always_ff @(posedge clk or negedge rst)
        if (!rst) count <= '0;
        else count <= count_next;
endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl: 32-bit load/store over a 16-bit async SRAM; define SRAM_STALL_CNT_EN to add stall_cycles
module mem_stage_sram_ctrl
    import mem_sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int          SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
`ifdef SRAM_STALL_CNT_EN
    output logic [31:0]        stall_cycles,
`endif
    input  logic [SRAM_DW-1:0] sram_dq_in
);
    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    state_t             state, state_n;
    logic               op_write, op_read, w_n, acc, acc_n, tc, we_n_n;
    logic [3:0]         cnt, cnt_n;
    logic [SRAM_AW-2:0] word;

    assign word  = (SRAM_AW - 1)'((address - BASE_ADDR) >> 2);
    assign acc   = state == ACC_LO || state == ACC_HI;
    assign ready = state == IDLE ? ~(wr_en | rd_en) : state == DONE;

    sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
        .clk       (clk),
        .rst       (rst),
        .clr       (~acc | tc),
        .en        (acc),
        .count     (cnt),
        .count_next(cnt_n),
        .tc        (tc)
    );

    // SRAM pins are registered, so they are decoded from next state and next count
    always_comb begin
        state_n = state == IDLE   ? ((wr_en | rd_en) ? ACC_LO : IDLE) :
                  state == ACC_LO ? (tc ? ACC_HI : ACC_LO) :
                  state == ACC_HI ? (tc ? DONE : ACC_HI) : IDLE;
        w_n     = state == IDLE ? wr_en : op_write;
        acc_n   = state_n == ACC_LO || state_n == ACC_HI;
        we_n_n  = ~(acc_n & w_n & (WAIT_CYCLES == 1 || cnt_n != LAST));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            op_write    <= 1'b0;
            op_read     <= 1'b0;
            read_data   <= '0;
            sram_we_n   <= 1'b1;
            sram_dq_oe  <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE) begin
                op_write <= wr_en;
                op_read  <= rd_en & ~wr_en;
            end
            if (op_read && tc && state == ACC_LO) read_data[15:0]  <= sram_dq_in;
            if (op_read && tc && state == ACC_HI) read_data[31:16] <= sram_dq_in;
            sram_we_n  <= we_n_n;
            sram_dq_oe <= acc_n & w_n;
            if (acc_n) begin
                sram_addr   <= {word, state_n == ACC_HI};
                sram_dq_out <= state_n == ACC_HI ? write_data[31:16] : write_data[15:0];
            end
        end
    end

`ifdef SRAM_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst) stall_cycles <= '0;
        else if (!ready) stall_cycles <= stall_cycles + 32'd1;
`endif
endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// tb_mem_stage_sram_ctrl: scoreboard bench with a word-level memory model and an SRAM pin model
module tb_mem_stage_sram_ctrl;
    import mem_sram_pkg::*;

    localparam int          W    = DEF_WAIT_CYCLES;
    localparam logic [31:0] BASE = DEF_BASE_ADDR;

    logic clk = 0, rst = 0;
    always #5 clk = ~clk;

    logic        wr_en = 0, rd_en = 0, ready, sram_dq_oe, sram_we_n;
    logic [31:0] address = 0, write_data = 0, read_data;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        wr1 = 0, rd1 = 0, ready1, oe1, we_n1;
    logic [31:0] addr1 = 0, wd1 = 0, read_data1;
    logic [17:0] sram_addr1;
    logic [15:0] dq_out1, dq_in1;
`ifdef SRAM_STALL_CNT_EN
    logic [31:0] stall_cycles, stall_cycles1;
`endif

    mem_stage_sram_ctrl dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_we_n(sram_we_n),
`ifdef SRAM_STALL_CNT_EN
        .stall_cycles(stall_cycles),
`endif
        .sram_dq_in(sram_dq_in)
    );

    mem_stage_sram_ctrl #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr1), .rd_en(rd1), .address(addr1),
        .write_data(wd1), .read_data(read_data1), .ready(ready1),
        .sram_addr(sram_addr1), .sram_dq_out(dq_out1), .sram_dq_oe(oe1),
        .sram_we_n(we_n1),
`ifdef SRAM_STALL_CNT_EN
        .stall_cycles(stall_cycles1),
`endif
        .sram_dq_in(dq_in1)
    );

    // SRAM pin models: real storage for the main DUT, an address-derived pattern for dut1
    logic [15:0] sram [0:511];
    assign sram_dq_in = sram[sram_addr[8:0]];
    assign dq_in1 = 16'(sram_addr1 ^ 18'h2A5A5);
    always @(negedge clk) if (rst && !sram_we_n && sram_dq_oe) sram[sram_addr[8:0]] <= sram_dq_out;

    typedef struct {
        bit          wr;
        logic [16:0] w;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } item_t;

    item_t       sb[$];
    logic [31:0] ref_mem [0:255];
    logic [31:0] last_rd;
    int          vectors = 0, miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic issue(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] off;
        item_t it;
        off = a - BASE;
        if (wr) ref_mem[off[9:2]] = d;
        else if (rd) last_rd = ref_mem[off[9:2]];
        it.wr = wr; it.w = off[18:2]; it.wdata = d; it.exp_rd = last_rd;
        if (wr | rd) sb.push_back(it);
        @(posedge clk); #1;
        wr_en = wr; rd_en = rd; address = a; write_data = d;
        if (wr | rd) begin
            for (int c = 0; ; c++) begin
                @(negedge clk);
                if (ready) break;
                if (c > 40) begin
                    vectors++; miscompares++;
                    $display("FAIL done_timeout: no ready after %0d cycles", c);
                    break;
                end
            end
        end else @(negedge clk);
    endtask

    logic [17:0] tr_a [0:63];
    logic [15:0] tr_d [0:63];
    logic        tr_we [0:63], tr_oe [0:63];
    int          k = 0, bad, c;
    bit          busy = 0, hi;
    item_t       cur;
    logic        e_we;

    always @(negedge clk) begin
        if (!rst) begin
            sb.delete(); busy = 0; k = 0;
        end else if (!ready) begin
            if (k < 64) begin
                tr_a[k] = sram_addr; tr_d[k] = sram_dq_out; tr_we[k] = sram_we_n; tr_oe[k] = sram_dq_oe;
            end
            k++; busy = 1;
        end else if (busy) begin
            busy = 0;
            if (sb.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL unexpected_done: no pending request");
            end else begin
                cur = sb.pop_front();
                check("busy_cycles", 64'(k), 64'(1 + 2 * W));
                bad = -1;
                for (int j = 0; j < 1 + 2 * W && j < 64; j++) begin
                    hi = j > W;
                    c = hi ? j - W - 1 : j - 1;
                    e_we = cur.wr ? (W > 1 && c == W - 1) : 1'b1;
                    if (j == 0) begin
                        if (bad < 0 && (tr_we[j] !== 1'b1 || tr_oe[j] !== 1'b0)) bad = j;
                    end else if (bad < 0 && (tr_we[j] !== e_we || tr_oe[j] !== cur.wr ||
                             tr_a[j] !== {cur.w, hi} ||
                             (cur.wr && tr_d[j] !== (hi ? cur.wdata[31:16] : cur.wdata[15:0]))))
                        bad = j;
                end
                check("trace_first_bad_cycle", 64'(bad), -64'sd1);
                check("read_data", read_data, cur.exp_rd);
                check("done_bus_idle", {sram_we_n, sram_dq_oe}, 2'b10);
            end
            k = 0;
        end else check("idle_bus", {sram_we_n, sram_dq_oe}, 2'b10);
    end

    logic [7:0]  pat;
    logic [31:0] off;

    initial begin
        for (int i = 0; i < 512; i++) sram[i] = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        last_rd = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_read_data", read_data, 32'h0);
        check("rst_we_n", sram_we_n, 1'b1);
        check("rst_oe", sram_dq_oe, 1'b0);
        check("rst_ready", ready, 1'b1);
        check("rst_sram_addr", sram_addr, 18'h0);
        rst = 1;

        issue(1, 0, 32'd1032, 32'h1234ABCD);
        issue(0, 1, 32'd1032, 32'h0);
        issue(0, 0, 32'h0, 32'h0);
        issue(0, 0, 32'h0, 32'h0);
        check("read_held", read_data, 32'h1234ABCD);
        issue(1, 1, 32'd1036, 32'hCAFE_F00D);
        issue(0, 1, 32'd1036, 32'h0);

        for (int n = 0; n < 80; n++) begin
            bit [1:0] op;
            op = 2'($urandom_range(0, 3));
            issue(op[1], op[0], BASE + 32'($urandom_range(0, 1023)), $urandom);
        end

        // abort a store during its high half
        @(posedge clk); #1;
        wr_en = 1; rd_en = 0; address = BASE + 32'd100; write_data = $urandom;
        repeat (3) @(posedge clk);
        #1 rst = 0; wr_en = 0;
        #1;
        check("abort_we_n", sram_we_n, 1'b1);
        check("abort_oe", sram_dq_oe, 1'b0);
        check("abort_read_data", read_data, 32'h0);
        @(posedge clk); #1 rst = 1;
        #1 check("abort_ready", ready, 1'b1);
        ref_mem[25] = {sram[51], sram[50]};
        last_rd = '0;
        issue(0, 1, BASE + 32'd200, 32'h0);
        issue(0, 1, BASE + 32'd100, 32'h0);
        for (int n = 0; n < 20; n++) begin
            bit [1:0] op;
            op = 2'($urandom_range(0, 3));
            issue(op[1], op[0], BASE + 32'($urandom_range(0, 1023)), $urandom);
        end
        issue(0, 0, 32'h0, 32'h0);
        for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        // single-cycle waits, back-to-back load then store
        @(posedge clk); #1;
        rd1 = 1; addr1 = BASE + 32'd40;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pat[i] = ready1;
            if (i == 3) begin
                check("w1_read_data", read_data1, {16'(18'd21 ^ 18'h2A5A5), 16'(18'd20 ^ 18'h2A5A5)});
                @(posedge clk); #1;
                rd1 = 0; wr1 = 1; wd1 = 32'h5555AAAA;
            end
            if (i == 7) begin
                @(posedge clk); #1;
                wr1 = 0;
            end
        end
        check("w1_ready_pattern", pat, 8'b1000_1000);
`ifdef SRAM_STALL_CNT_EN
        check("w1_stall_cycles", stall_cycles1, 32'd6);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
